// File: rtl/setup_chain_ctrl_pkg.sv
// setup_ctrl_pkg: shared width and state encodings for the setup register chain sequencer
package setup_ctrl_pkg;
    localparam int SETUP_W = 8;
    typedef enum logic [2:0] {LOAD, SHIFT, COMMIT, IDLE, ERR} state_t;
    typedef enum logic {SRC_BOOT, SRC_HOST} src_t;
endpackage

// File: rtl/setup_chain_ctrl_serializer.sv
// setup_serializer: 8-bit parallel-load, LSB-first shift-out register with bit counter
module setup_serializer
    import setup_ctrl_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               load_in,
    input  logic               shift_in,
    input  logic [SETUP_W-1:0] value_in,
    output logic               bit_out,
    output logic               last_bit_out
);
    logic [SETUP_W-1:0] r_sr;
    logic [2:0]         r_cnt;
    // load restarts the bit count; each shift exposes the next bit on r_sr[0]
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (load_in) begin
            r_sr  <= value_in;
            r_cnt <= '0;
        end else if (shift_in) begin
            r_sr  <= r_sr >> 1;
            r_cnt <= r_cnt + 3'd1;
        end
    assign bit_out      = r_sr[0];
    assign last_bit_out = (r_cnt == 3'd7);
endmodule

// File: rtl/setup_chain_ctrl.sv
// setup_chain_ctrl: boots every setup register from DEFAULTS, then serializes host writes into one register
module setup_chain_ctrl
    import setup_ctrl_pkg::*;
#(
    parameter int                      NUM_REGS = 4,
    parameter int                      ADDR_W   = 2,
    parameter logic [NUM_REGS*8-1:0]   DEFAULTS = '0
)(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                wr_valid_in,
    output logic                wr_ready_out,
    input  logic [ADDR_W-1:0]   wr_addr_in,
    input  logic [7:0]          wr_data_in,
    input  logic                reload_in,
    output logic                serial_out,
    output logic [NUM_REGS-1:0] shift_en_out,
    output logic [NUM_REGS-1:0] cfg_valid_out,
    output logic                all_valid_out,
    output logic                done_out,
    output logic                err_out
);
    state_t              r_state, w_next;
    src_t                r_src;
    logic [ADDR_W-1:0]   r_idx;
    logic [SETUP_W-1:0]  r_data;
    logic [NUM_REGS-1:0] r_valid;
    logic [NUM_REGS-1:0] w_hot;
    logic [SETUP_W-1:0]  w_boot_val;
    logic                w_load, w_shift, w_bit, w_last, w_addr_ok, w_more;

    assign w_addr_ok = 32'(wr_addr_in) < NUM_REGS;
    assign w_more    = (r_src == SRC_BOOT) && (32'(r_idx) < NUM_REGS - 1);

    // one-hot decode of the current index and the matching boot default slice
    always_comb begin
        w_hot      = '0;
        w_boot_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            w_hot[k] = (32'(r_idx) == k);
            if (w_hot[k]) w_boot_val = DEFAULTS[k*SETUP_W +: SETUP_W];
        end
    end

    setup_serializer u_ser (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .load_in     (w_load),
        .shift_in    (w_shift),
        .value_in    ((r_src == SRC_BOOT) ? w_boot_val : r_data),
        .bit_out     (w_bit),
        .last_bit_out(w_last)
    );

    // state register; async reset restarts the boot sequence
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) r_state <= LOAD;
        else        r_state <= w_next;

    // next-state and strobes; ready never looks at wr_valid_in, and reload wins over a write
    always_comb begin
        w_next       = r_state;
        wr_ready_out = 1'b0;
        done_out     = 1'b0;
        err_out      = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            LOAD: begin
                w_load = 1'b1;
                w_next = SHIFT;
            end
            SHIFT: begin
                w_shift = 1'b1;
                w_next  = w_last ? COMMIT : SHIFT;
            end
            COMMIT: begin
                done_out = 1'b1;
                w_next   = w_more ? LOAD : IDLE;
            end
            IDLE: begin
                wr_ready_out = !reload_in;
                w_next       = reload_in ? LOAD : !wr_valid_in ? IDLE : w_addr_ok ? LOAD : ERR;
            end
            ERR: begin
                err_out = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = LOAD;
        endcase
    end

    // source, index, captured write data and sticky valid flags
    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            r_src   <= SRC_BOOT;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= '0;
        end else if (r_state == COMMIT) begin
            r_valid <= r_valid | w_hot;
            if (w_more) r_idx <= r_idx + 1'b1;
        end else if (r_state == IDLE) begin
            if (reload_in) begin
                r_valid <= '0;
                r_src   <= SRC_BOOT;
                r_idx   <= '0;
            end else if (wr_valid_in && w_addr_ok) begin
                r_src  <= SRC_HOST;
                r_idx  <= wr_addr_in;
                r_data <= wr_data_in;
            end
        end

    assign shift_en_out  = (r_state == SHIFT) ? w_hot : '0;
    assign serial_out    = (r_state == SHIFT) & w_bit;
    assign cfg_valid_out = r_valid;
    assign all_valid_out = &r_valid;
endmodule

// File: tb/tb_setup_chain_ctrl.sv
// tb_setup_chain_ctrl: table-driven boot checks plus directed write/error/reset/reload sequences
module tb_setup_chain_ctrl;
    logic       clk = 0, rst = 1, wr_valid = 0, reload = 0;
    logic [2:0] wr_addr = 0;
    logic [7:0] wr_data = 0;
    logic       wr_ready, serial, all_valid, done, err;
    logic [3:0] shift_en, cfg_valid;

    int n_chk = 0, n_pass = 0;
    int n_done = 0, n_err = 0, n_shift = 0, n_multi = 0;
    logic [7:0] mreg [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
    logic [31:0] defs = 32'hA5C33C81;
    logic [2:0] wa [3] = '{3'd0, 3'd1, 3'd3};
    logic [7:0] wd [3] = '{8'h11, 8'h22, 8'h33};

    typedef struct {
        int         cyc;
        logic [3:0] en;
        logic       ser;
        logic       dn;
        logic       rd;
        logic [3:0] vl;
    } vec_t;
    vec_t vt[$];

    setup_chain_ctrl #(.NUM_REGS(4), .ADDR_W(3), .DEFAULTS(32'hA5C33C81)) dut (
        .clk_in(clk), .rst_in(rst), .wr_valid_in(wr_valid), .wr_ready_out(wr_ready),
        .wr_addr_in(wr_addr), .wr_data_in(wr_data), .reload_in(reload), .serial_out(serial),
        .shift_en_out(shift_en), .cfg_valid_out(cfg_valid), .all_valid_out(all_valid),
        .done_out(done), .err_out(err)
    );

    always #5 clk = ~clk;

    // model of the external setup registers plus event counters, sampled mid-cycle
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++)
            if (shift_en[k]) mreg[k] <= {serial, mreg[k][7:1]};
        if (done) n_done++;
        if (err) n_err++;
        if (|shift_en) n_shift++;
        if ($countones(shift_en) > 1) n_multi++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] snap();
        return {19'b0, shift_en, serial, done, wr_ready, cfg_valid, all_valid, err};
    endfunction

    task automatic run_boot(string tag);
        #1;
        for (int i = 0; i < vt.size(); i++) begin
            if (i > 0) step();
            chk($sformatf("%s_c%0d", tag, vt[i].cyc), snap(),
                {19'b0, vt[i].en, vt[i].ser, vt[i].dn, vt[i].rd, vt[i].vl, &vt[i].vl, 1'b0});
        end
    endtask

    initial begin
        int s0, d0, n, cyc;
        int acc [3];
        for (int k = 0; k < 4; k++) begin
            logic [3:0] vm, oh;
            vm = 4'((1 << k) - 1);
            oh = 4'(1 << k);
            vt.push_back('{10*k, 4'b0, 1'b0, 1'b0, 1'b0, vm});
            for (int b = 0; b < 8; b++)
                vt.push_back('{10*k + 1 + b, oh, defs[8*k + b], 1'b0, 1'b0, vm});
            vt.push_back('{10*k + 9, 4'b0, 1'b0, 1'b1, 1'b0, vm});
        end
        vt.push_back('{40, 4'b0, 1'b0, 1'b0, 1'b1, 4'hF});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", snap(), 32'h0);
        rst = 0;
        run_boot("boot");
        chk("boot_reg0", 32'(mreg[0]), 32'h81);
        chk("boot_reg1", 32'(mreg[1]), 32'h3C);
        chk("boot_reg2", 32'(mreg[2]), 32'hC3);
        chk("boot_reg3", 32'(mreg[3]), 32'hA5);

        wr_valid = 1; wr_addr = 2; wr_data = 8'h6E;
        #1;
        chk("wr_ready_t", 32'(wr_ready), 32'h1);
        step();
        wr_valid = 0;
        #1;
        chk("wr_load", {27'b0, shift_en, wr_ready}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("wr_shift_b%0d", i), 32'(shift_en), 32'h4);
        end
        step();
        chk("wr_done", {29'b0, done, shift_en == 4'b0, wr_ready}, 32'h6);
        step();
        chk("wr_ready_again", 32'(wr_ready), 32'h1);
        chk("wr_regs", {mreg[3], mreg[2], mreg[1], mreg[0]}, 32'hA56E3C81);
        chk("wr_valid_kept", 32'(cfg_valid), 32'hF);

        s0 = n_shift;
        wr_valid = 1; wr_addr = 5; wr_data = 8'hFF;
        #1;
        chk("bad_ready", 32'(wr_ready), 32'h1);
        step();
        wr_valid = 0;
        #1;
        chk("bad_err", {27'b0, err, shift_en}, 32'h10);
        step();
        chk("bad_recover", {30'b0, wr_ready, err}, 32'h2);
        chk("bad_no_shift", n_shift, s0);
        chk("bad_err_count", n_err, 1);
        chk("bad_valid", 32'(cfg_valid), 32'hF);

        wr_valid = 1; wr_addr = 1; wr_data = 8'h55;
        #1;
        step();
        wr_valid = 0;
        repeat (5) step();
        chk("pre_rst_shift", 32'(shift_en), 32'h2);
        rst = 1;
        #1;
        chk("rst_async", {22'b0, shift_en, cfg_valid, wr_ready, serial}, 32'h0);
        step();
        step();
        rst = 0;
        run_boot("reboot");
        chk("reboot_regs", {mreg[3], mreg[2], mreg[1], mreg[0]}, 32'hA5C33C81);

        reload = 1; wr_valid = 1; wr_addr = 3; wr_data = 8'h99;
        #1;
        chk("reload_ready", 32'(wr_ready), 32'h0);
        step();
        reload = 0;
        #1;
        chk("reload_clear", 32'(cfg_valid), 32'h0);
        run_boot("reload");
        step();
        wr_valid = 0;
        repeat (9) step();
        chk("held_done", 32'(done), 32'h1);
        step();
        chk("held_ready", 32'(wr_ready), 32'h1);
        chk("held_reg3", 32'(mreg[3]), 32'h99);

        n = 0; cyc = 0; d0 = n_done;
        acc = '{0, 0, 0};
        wr_valid = 1;
        while (n < 3 && cyc < 60) begin
            wr_addr = wa[n]; wr_data = wd[n];
            #1;
            if (wr_ready) begin
                acc[n] = cyc;
                n++;
            end
            step();
            cyc++;
        end
        wr_valid = 0;
        repeat (10) step();
        chk("b2b_count", n, 3);
        chk("b2b_gap1", acc[1] - acc[0], 11);
        chk("b2b_gap2", acc[2] - acc[1], 11);
        chk("b2b_dones", n_done - d0, 3);
        chk("b2b_regs", {mreg[3], mreg[2], mreg[1], mreg[0]}, 32'h33C32211);
        chk("onehot_en", n_multi, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/setup_chain_ctrl.md
# setup_chain_ctrl

Sequencer that owns the FP adder's chain of 8-bit serial setup registers. It loads compile-time defaults into every register after reset or on request, then serializes host writes into one addressed register. Each register is driven through a shared serial data line and a per-register one-hot shift enable. It sits between the host/config port and the setup registers.

## Interface
- NUM_REGS, 4, number of setup registers driven (1..16)
- ADDR_W, 2, width of wr_addr_in (≥ clog2(NUM_REGS), min 1)
- DEFAULTS, 32'h0, NUM_REGS*8 packed boot values; register k takes DEFAULTS[8k+7:8k]

- clk_in  in  1  single clock, all logic rising-edge
- rst_in  in  1  asynchronous, active-high reset
- wr_valid_in  in  1  host write request
- wr_ready_out  out  1  write accepted on edge with wr_valid_in & wr_ready_out
- wr_addr_in  in  ADDR_W  target register index
- wr_data_in  in  8  value to load
- reload_in  in  1  single-cycle request to re-run the default load
- serial_out  out  1  serial data to all setup registers
- shift_en_out  out  NUM_REGS  one-hot shift enable, bit k = register k
- cfg_valid_out  out  NUM_REGS  sticky: register k loaded since last reset/reload
- all_valid_out  out  1  &cfg_valid_out
- done_out  out  1  one-cycle pulse per completed register load
- err_out  out  1  one-cycle pulse on out-of-range write

## Operation
- States: LOAD, SHIFT, COMMIT, IDLE, ERR. Source flag boot/host; index register idx.
- Reset: state LOAD, source boot, idx 0, bit counter 0. All outputs 0 (wr_ready_out 0, shift_en_out 0, serial_out 0, cfg_valid_out 0).
- LOAD: latch 8-bit value (DEFAULTS slice for boot, captured wr_data_in for host) into the serializer; bit counter cleared; enables low. Next state SHIFT.
- SHIFT: 8 cycles. In SHIFT cycle b (b=0..7): serial_out = value[b] (LSB first), shift_en_out = one-hot(idx). After b=7, next state COMMIT. After the 8th shift, the target register holds the value with bit 0 in position 0.
- COMMIT: enables low, serial_out 0. done_out=1, cfg_valid_out[idx] set. If boot and idx<NUM_REGS-1: idx++, next state LOAD. Otherwise next state IDLE.
- IDLE: wr_ready_out=1, except when reload_in=1 in that cycle (then 0).
  - reload_in=1: clear cfg_valid_out, set source boot, set idx 0, next state LOAD. reload_in has priority over a simultaneous wr_valid_in; that write is not accepted and must be held by the host.
  - Write handshake with wr_addr_in < NUM_REGS: capture address and data, source host, next state LOAD.
  - Write handshake with wr_addr_in ≥ NUM_REGS: next state ERR; no shift.
- ERR: err_out=1 for one cycle; next state IDLE. cfg_valid_out unchanged.
- reload_in outside IDLE is ignored (not queued).
- Host rewrite of an already-valid register leaves cfg_valid_out[idx] set.

## Timing
- Boot: cycle 0 is the first cycle after rst_in falls. Register k: LOAD in cycle 10k, SHIFT in 10k+1..10k+8, COMMIT in 10k+9. IDLE and wr_ready_out=1 from cycle 10·NUM_REGS (40 by default).
- Host write accepted on the edge ending cycle t: LOAD t+1, SHIFT t+2..t+9, done_out at t+10, wr_ready_out high again at t+11. Throughput is one write per 11 cycles.
- Out-of-range write accepted at t: err_out at t+1, ready again at t+2.
- wr_ready_out depends only on state and reload_in (no combinational path from wr_valid_in).
- Reset mid-operation: outputs clear asynchronously; shift_en_out drops the same instant. After release, the full boot sequence restarts from idx 0.
- shift_en_out is never non-zero outside SHIFT, and at most one bit is ever set.

## Structure
- Package setup_ctrl_pkg holds SETUP_W=8 and the state enum (LOAD, SHIFT, COMMIT, IDLE, ERR).
- Sub-module setup_serializer: 8-bit load/shift-out register with 3-bit bit counter and last_bit flag. The controller FSM, index and cfg_valid logic live in setup_chain_ctrl.

## Test plan
- Boot, DEFAULTS=32'hA5C33C81 -> register 0 receives bits 1,0,0,0,0,0,0,1 in cycles 1–8 with shift_en_out=4'b0001. done_out in cycles 9/19/29/39. all_valid_out=1 and wr_ready_out=1 at cycle 40. Modelled registers read 81,3C,C3,A5.
- Host write addr 2, data 8'h6E at cycle t -> shift_en_out=4'b0100 during t+2..t+9, register 2 = 6E, done_out at t+10. Other registers unchanged.
- Write addr 5 with ADDR_W=3, NUM_REGS=4 -> err_out at t+1, no shift_en activity, cfg_valid_out unchanged, ready at t+2.
- rst_in asserted during SHIFT bit 4 of a host write -> shift_en_out=0 immediately, cfg_valid_out=0. Boot restarts at cycle 0 after release and completes at cycle 40.
- reload_in and wr_valid_in both high in IDLE -> wr_ready_out=0, cfg_valid_out cleared next cycle. Boot reload completes in 40 cycles, then the held write is accepted.
- wr_valid_in held high with 3 back-to-back writes (addr 0,1,3) -> accepts spaced exactly 11 cycles apart, three done_out pulses, correct values loaded.
